// File: rtl/uart_rx_fifo_param.sv
// UART receiver (5-8 data bits, optional parity, 1/2 stop bits) feeding a receive FIFO
// whose entries carry {data, parity error, framing error}. Break detection: UART_RX_BREAK_DETECT_EN.
module uart_rx_fifo_param #(
  parameter int OVERSAMPLE = 16,
  parameter int FIFO_DEPTH = 8,
  parameter int LVL_W      = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             baud_clock,
  input  logic [1:0]       data_len,
  input  logic             parity_en,
  input  logic             odd_n_even,
  input  logic             two_stop,
  input  logic             rx,
  input  logic             rd_en,
  input  logic             clear_status,
  output logic [7:0]       rx_data,
  output logic             rx_parity_err,
  output logic             rx_framing_err,
  output logic             rx_valid,
  output logic [LVL_W-1:0] fifo_level,
  output logic             overflow,
  output logic             break_det,
  output logic             rx_idle
);

  localparam int CW = $clog2(OVERSAMPLE);
  localparam int AW = $clog2(FIFO_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PARITY, S_STOP1, S_STOP2
  } state_t;

  state_t        state, state_d;
  logic [2:0]    samp;
  logic          rxf;
  logic [CW-1:0] cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    data_r;
  logic          armed;
  logic [1:0]    cfg_len;
  logic          cfg_par, cfg_odd, cfg_two;
  logic          perr_r, ferr_r;
  logic          mid_pt, half_pt, last_bit;
  logic          done, entry_ferr, frame_zero, wr_req;

  assign rxf      = (samp[0] & samp[1]) | (samp[0] & samp[2]) | (samp[1] & samp[2]);
  assign mid_pt   = (cnt == CW'(OVERSAMPLE - 1));
  assign half_pt  = (cnt == CW'(OVERSAMPLE / 2 - 1));
  assign last_bit = (bit_idx == ({1'b0, cfg_len} + 3'd4));

  always_comb begin
    state_d    = state;
    done       = 1'b0;
    entry_ferr = 1'b0;
    if (baud_clock) begin
      case (state)
        S_IDLE:   if (armed && !rxf) state_d = S_START;
        S_START:  if (half_pt) state_d = rxf ? S_IDLE : S_DATA;
        S_DATA:   if (mid_pt && last_bit) state_d = cfg_par ? S_PARITY : S_STOP1;
        S_PARITY: if (mid_pt) state_d = S_STOP1;
        S_STOP1: begin
          if (mid_pt) begin
            entry_ferr = ~rxf;
            if (cfg_two) begin
              state_d = S_STOP2;
            end else begin
              state_d = S_IDLE;
              done    = 1'b1;
            end
          end
        end
        S_STOP2: begin
          if (mid_pt) begin
            entry_ferr = ferr_r | ~rxf;
            state_d    = S_IDLE;
            done       = 1'b1;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  assign wr_req  = done & ~frame_zero;
  assign rx_idle = (state == S_IDLE);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state   <= S_IDLE;
      samp    <= 3'b111;
      cnt     <= '0;
      bit_idx <= '0;
      data_r  <= '0;
      armed   <= 1'b0;
      cfg_len <= '0;
      cfg_par <= 1'b0;
      cfg_odd <= 1'b0;
      cfg_two <= 1'b0;
      perr_r  <= 1'b0;
      ferr_r  <= 1'b0;
    end else begin
      state <= state_d;
      if (baud_clock) begin
        samp <= {samp[1:0], rx};
        cnt  <= cnt + 1'b1;
        case (state)
          S_IDLE: begin
            cnt <= '0;
            if (rxf) armed <= 1'b1;
            // Configuration is frozen for the whole frame at its start edge.
            if (armed && !rxf) begin
              cfg_len <= data_len;
              cfg_par <= parity_en;
              cfg_odd <= odd_n_even;
              cfg_two <= two_stop;
              data_r  <= '0;
              bit_idx <= '0;
              perr_r  <= 1'b0;
              ferr_r  <= 1'b0;
            end
          end
          S_START: if (half_pt) cnt <= '0;
          S_DATA: begin
            if (mid_pt) begin
              cnt             <= '0;
              data_r[bit_idx] <= rxf;
              bit_idx         <= bit_idx + 3'd1;
            end
          end
          S_PARITY: begin
            if (mid_pt) begin
              cnt    <= '0;
              perr_r <= ((^data_r) ^ rxf) != cfg_odd;
            end
          end
          S_STOP1: begin
            if (mid_pt) begin
              cnt    <= '0;
              ferr_r <= ~rxf;
            end
          end
          S_STOP2: if (mid_pt) cnt <= '0;
          default: cnt <= '0;
        endcase
        // After a completed frame the line must be seen high before the next start.
        if (done) armed <= 1'b0;
      end
    end
  end

`ifdef UART_RX_BREAK_DETECT_EN
  logic par_bit, stop1_low;

  assign frame_zero = (data_r == 8'd0) && !(cfg_par && par_bit) && !rxf &&
                      ((state == S_STOP1) || stop1_low);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      par_bit   <= 1'b0;
      stop1_low <= 1'b0;
      break_det <= 1'b0;
    end else begin
      if (baud_clock && mid_pt && state == S_PARITY) par_bit <= rxf;
      if (baud_clock && mid_pt && state == S_STOP1) stop1_low <= ~rxf;
      if (done && frame_zero) break_det <= 1'b1;
      else if (clear_status) break_det <= 1'b0;
    end
  end
`else
  assign frame_zero = 1'b0;
  assign break_det  = 1'b0;
`endif

  // Read side: rx_valid means the head entry is presented; a one-clk rd_en pulse
  // pops it. rd_en while rx_valid=0 has no effect.
  logic [9:0]       mem [FIFO_DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [LVL_W-1:0] count;
  logic             full, do_rd, do_wr;
  logic [9:0]       head;

  assign full  = (count == LVL_W'(FIFO_DEPTH));
  assign do_rd = rd_en && (count != '0);
  assign do_wr = wr_req && (!full || do_rd);
  assign head  = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr] <= {data_r, perr_r, entry_ferr};
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + 1'b1;
      if (do_rd) rd_ptr <= rd_ptr + 1'b1;
      case ({do_wr, do_rd})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (wr_req && !do_wr) overflow <= 1'b1;
      else if (clear_status) overflow <= 1'b0;
    end
  end

  assign rx_valid       = (count != '0);
  assign fifo_level     = count;
  assign rx_data        = rx_valid ? head[9:2] : 8'd0;
  assign rx_parity_err  = rx_valid & head[1];
  assign rx_framing_err = rx_valid & head[0];

endmodule

// File: tb/tb_uart_rx_fifo_param.sv
// Directed bench for uart_rx_fifo_param (OVERSAMPLE=16, FIFO_DEPTH=8); baud_clock every 2nd clk.
module tb_uart_rx_fifo_param;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       baud_clock = 1'b0;
  logic [1:0] data_len = 2'b11;
  logic       parity_en = 1'b0;
  logic       odd_n_even = 1'b0;
  logic       two_stop = 1'b0;
  logic       rx = 1'b1;
  logic       rd_en = 1'b0;
  logic       clear_status = 1'b0;
  logic [7:0] rx_data;
  logic       rx_parity_err, rx_framing_err, rx_valid;
  logic [3:0] fifo_level;
  logic       overflow, break_det, rx_idle;

  int checks = 0;
  int failures = 0;

  localparam int BIT_CLKS = 32;

  uart_rx_fifo_param #(.OVERSAMPLE(16), .FIFO_DEPTH(8), .LVL_W(4)) dut (
    .clk(clk), .reset_n(reset_n), .baud_clock(baud_clock), .data_len(data_len),
    .parity_en(parity_en), .odd_n_even(odd_n_even), .two_stop(two_stop), .rx(rx),
    .rd_en(rd_en), .clear_status(clear_status), .rx_data(rx_data),
    .rx_parity_err(rx_parity_err), .rx_framing_err(rx_framing_err), .rx_valid(rx_valid),
    .fifo_level(fifo_level), .overflow(overflow), .break_det(break_det), .rx_idle(rx_idle)
  );

  // Clock and baud enable
  always #5 clk = ~clk;
  always @(posedge clk) baud_clock <= ~baud_clock;

  // Driver tasks
  task automatic send_bit(input logic b);
    rx = b;
    repeat (BIT_CLKS) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input int nbits, input logic pen,
                            input logic pbit, input logic s2bit);
    send_bit(1'b0);
    for (int i = 0; i < nbits; i++) send_bit(d[i]);
    if (pen) send_bit(pbit);
    send_bit(1'b1);
    if (two_stop) send_bit(s2bit);
    send_bit(1'b1);
    send_bit(1'b1);
  endtask

  task automatic set_cfg(input logic [1:0] len, input logic pen, input logic odd, input logic two);
    @(negedge clk);
    data_len = len; parity_en = pen; odd_n_even = odd; two_stop = two;
  endtask

  task automatic pop();
    @(negedge clk) rd_en = 1'b1;
    @(negedge clk) rd_en = 1'b0;
  endtask

  task automatic pulse_clear();
    @(negedge clk) clear_status = 1'b1;
    @(negedge clk) clear_status = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (4) @(negedge clk);
    checks++; if (rx_valid !== 1'b0) begin failures++; $display("FAIL reset_valid actual=%b expected=0", rx_valid); end
    checks++; if (fifo_level !== 4'd0) begin failures++; $display("FAIL reset_level actual=%0d expected=0", fifo_level); end
    checks++; if (rx_data !== 8'h00) begin failures++; $display("FAIL reset_data actual=%h expected=00", rx_data); end
    checks++; if ({overflow, break_det} !== 2'b00) begin failures++; $display("FAIL reset_sticky actual=%b expected=00", {overflow, break_det}); end
    checks++; if (rx_idle !== 1'b1) begin failures++; $display("FAIL reset_idle actual=%b expected=1", rx_idle); end
    reset_n = 1'b1;
    repeat (BIT_CLKS) @(negedge clk);
  endtask

  task automatic test_8n1();
    set_cfg(2'b11, 1'b0, 1'b0, 1'b0);
    send_frame(8'hA5, 8, 1'b0, 1'b0, 1'b1);
    checks++; if (rx_valid !== 1'b1) begin failures++; $display("FAIL 8n1_valid actual=%b expected=1", rx_valid); end
    checks++; if (rx_data !== 8'hA5) begin failures++; $display("FAIL 8n1_data actual=%h expected=a5", rx_data); end
    checks++; if ({rx_parity_err, rx_framing_err} !== 2'b00) begin failures++; $display("FAIL 8n1_flags actual=%b expected=00", {rx_parity_err, rx_framing_err}); end
    checks++; if (fifo_level !== 4'd1) begin failures++; $display("FAIL 8n1_level actual=%0d expected=1", fifo_level); end
    checks++; if (rx_idle !== 1'b1) begin failures++; $display("FAIL 8n1_idle actual=%b expected=1", rx_idle); end
    pop();
    checks++; if (rx_valid !== 1'b0) begin failures++; $display("FAIL 8n1_pop actual=%b expected=0", rx_valid); end
  endtask

  task automatic test_7e1_parity();
    set_cfg(2'b10, 1'b1, 1'b0, 1'b0);
    // 0x41 has two ones; a parity bit of 1 makes the total odd, wrong for even parity
    send_frame(8'h41, 7, 1'b1, 1'b1, 1'b1);
    checks++; if (rx_data !== 8'h41) begin failures++; $display("FAIL 7e1_data actual=%h expected=41", rx_data); end
    checks++; if (rx_parity_err !== 1'b1) begin failures++; $display("FAIL 7e1_perr actual=%b expected=1", rx_parity_err); end
    checks++; if (rx_framing_err !== 1'b0) begin failures++; $display("FAIL 7e1_ferr actual=%b expected=0", rx_framing_err); end
    pop();
    checks++; if (rx_valid !== 1'b0) begin failures++; $display("FAIL 7e1_pop actual=%b expected=0", rx_valid); end
    // 5O1 with correct odd parity: 0x13 has three ones, parity bit 0
    set_cfg(2'b00, 1'b1, 1'b1, 1'b0);
    send_frame(8'h13, 5, 1'b1, 1'b0, 1'b1);
    checks++; if ({rx_data, rx_parity_err, rx_framing_err} !== {8'h13, 2'b00}) begin failures++; $display("FAIL 5o1_entry actual=%h/%b%b expected=13/00", rx_data, rx_parity_err, rx_framing_err); end
    pop();
  endtask

  task automatic test_8n2_framing();
    set_cfg(2'b11, 1'b0, 1'b0, 1'b1);
    send_frame(8'h3C, 8, 1'b0, 1'b0, 1'b0);
    checks++; if (rx_data !== 8'h3C) begin failures++; $display("FAIL 8n2_data actual=%h expected=3c", rx_data); end
    checks++; if (rx_framing_err !== 1'b1) begin failures++; $display("FAIL 8n2_ferr actual=%b expected=1", rx_framing_err); end
    checks++; if (rx_parity_err !== 1'b0) begin failures++; $display("FAIL 8n2_perr actual=%b expected=0", rx_parity_err); end
    pop();
    checks++; if (fifo_level !== 4'd0) begin failures++; $display("FAIL 8n2_pop_level actual=%0d expected=0", fifo_level); end
  endtask

  task automatic test_overflow();
    set_cfg(2'b11, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 9; i++) send_frame(8'h10 + 8'(i), 8, 1'b0, 1'b0, 1'b1);
    checks++; if (fifo_level !== 4'd8) begin failures++; $display("FAIL ovf_level actual=%0d expected=8", fifo_level); end
    checks++; if (overflow !== 1'b1) begin failures++; $display("FAIL ovf_flag actual=%b expected=1", overflow); end
    checks++; if (rx_data !== 8'h10) begin failures++; $display("FAIL ovf_head actual=%h expected=10", rx_data); end
    pulse_clear();
    checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL ovf_clear actual=%b expected=0", overflow); end
    for (int i = 0; i < 8; i++) begin
      checks++; if (rx_data !== 8'h10 + 8'(i)) begin failures++; $display("FAIL ovf_order%0d actual=%h expected=%h", i, rx_data, 8'h10 + 8'(i)); end
      pop();
    end
    checks++; if (fifo_level !== 4'd0) begin failures++; $display("FAIL ovf_drain actual=%0d expected=0", fifo_level); end
  endtask

  task automatic test_glitch();
    @(negedge clk) rx = 1'b0;
    repeat (8) @(negedge clk);
    rx = 1'b1;
    repeat (2 * BIT_CLKS) @(negedge clk);
    checks++; if (rx_idle !== 1'b1) begin failures++; $display("FAIL glitch_idle actual=%b expected=1", rx_idle); end
    checks++; if (fifo_level !== 4'd0) begin failures++; $display("FAIL glitch_level actual=%0d expected=0", fifo_level); end
  endtask

  task automatic test_break();
    set_cfg(2'b11, 1'b0, 1'b0, 1'b0);
    @(negedge clk) rx = 1'b0;
    repeat (12 * BIT_CLKS) @(negedge clk);
    rx = 1'b1;
    repeat (2 * BIT_CLKS) @(negedge clk);
`ifdef UART_RX_BREAK_DETECT_EN
    checks++; if (break_det !== 1'b1) begin failures++; $display("FAIL break_flag actual=%b expected=1", break_det); end
    checks++; if (fifo_level !== 4'd0) begin failures++; $display("FAIL break_level actual=%0d expected=0", fifo_level); end
    pulse_clear();
    checks++; if (break_det !== 1'b0) begin failures++; $display("FAIL break_clear actual=%b expected=0", break_det); end
`else
    checks++; if (fifo_level !== 4'd1) begin failures++; $display("FAIL break_level actual=%0d expected=1", fifo_level); end
    checks++; if ({rx_data, rx_framing_err} !== {8'h00, 1'b1}) begin failures++; $display("FAIL break_entry actual=%h/%b expected=00/1", rx_data, rx_framing_err); end
    checks++; if (break_det !== 1'b0) begin failures++; $display("FAIL break_tied actual=%b expected=0", break_det); end
`endif
  endtask

  task automatic test_reset_mid_frame();
    send_frame(8'h5A, 8, 1'b0, 1'b0, 1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b0);
    reset_n = 1'b0;
    @(negedge clk);
    checks++; if (fifo_level !== 4'd0) begin failures++; $display("FAIL rstmid_level actual=%0d expected=0", fifo_level); end
    checks++; if (rx_idle !== 1'b1) begin failures++; $display("FAIL rstmid_idle actual=%b expected=1", rx_idle); end
    checks++; if ({rx_valid, rx_parity_err, rx_framing_err, overflow, break_det} !== 5'b0) begin failures++; $display("FAIL rstmid_flags actual=%b expected=00000", {rx_valid, rx_parity_err, rx_framing_err, overflow, break_det}); end
    reset_n = 1'b1;
    rx = 1'b1;
    repeat (2 * BIT_CLKS) @(negedge clk);
    send_frame(8'hC3, 8, 1'b0, 1'b0, 1'b1);
    checks++; if ({fifo_level, rx_data} !== {4'd1, 8'hC3}) begin failures++; $display("FAIL rstmid_recover actual=%0d/%h expected=1/c3", fifo_level, rx_data); end
  endtask

  initial begin
    test_reset();
    test_8n1();
    test_7e1_parity();
    test_8n2_framing();
    test_glitch();
    test_overflow();
    test_break();
    test_reset_mid_frame();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
